// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: breaks byte/half/word requests into single-byte
// accesses on an 8-bit memory port, most-significant byte first, and returns one response.
module mem_access_unit #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_writeData,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  input  logic [7:0]        mem_readData
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic [1:0]        last_q;
  logic [1:0]        idx_q;
  logic              wr_q;
  logic              uns_q;

  logic [1:0]        req_last;
  logic [ADDR_W-1:0] req_end;
  logic              req_err;
  logic [31:0]       load_shift;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] last,
                                         input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = v[7:0];
    h = v[15:0];
    case (last)
      2'd0:    extend = uns ? {24'd0, v[7:0]}  : 32'(b);
      2'd1:    extend = uns ? {16'd0, v[15:0]} : 32'(h);
      default: extend = v;
    endcase
  endfunction

  // Acceptance-time checks: alignment, bad size, and range including wrap past 2^ADDR_W.
  always_comb begin
    req_last = 2'd0;
    case (req_size)
      2'b01:   req_last = 2'd1;
      2'b10:   req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
    req_end = req_addr + ADDR_W'(req_last);
    req_err = (req_size == 2'b11)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b10 && (req_addr[1:0] != 2'b00))
            || (req_addr >= MEM_LIMIT) || (req_end >= MEM_LIMIT);
    load_shift = {data_q[23:0], mem_readData};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
      mem_memWrite  <= 1'b0;
      mem_memRead   <= 1'b0;
      base_q        <= '0;
      wdata_q       <= '0;
      data_q        <= '0;
      last_q        <= '0;
      idx_q         <= '0;
      wr_q          <= 1'b0;
      uns_q         <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            base_q    <= req_addr;
            wdata_q   <= req_wdata;
            last_q    <= req_last;
            wr_q      <= req_write;
            uns_q     <= req_unsigned;
            idx_q     <= '0;
            data_q    <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state        <= ACCESS;
              mem_address  <= req_addr;
              mem_memRead  <= ~req_write;
              mem_memWrite <= req_write;
              if (req_write) mem_writeData <= byte_sel(req_wdata, req_last);
            end
          end
        end
        // ---- one byte per cycle; load byte captured at the edge closing the cycle
        ACCESS: begin
          if (!wr_q) data_q <= load_shift;
          if (idx_q == last_q) begin
            state        <= RESP;
            mem_memRead  <= 1'b0;
            mem_memWrite <= 1'b0;
            resp_valid   <= 1'b1;
            resp_err     <= 1'b0;
            resp_rdata   <= wr_q ? 32'd0 : extend(load_shift, last_q, uns_q);
          end else begin
            idx_q       <= idx_q + 2'd1;
            mem_address <= base_q + ADDR_W'(idx_q + 2'd1);
            if (wr_q) mem_writeData <= byte_sel(wdata_q, last_q - idx_q - 2'd1);
          end
        end
        // ---- response cycle; ready returns on the following cycle
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
